// File: rtl/rf_pkg.sv
// Shared register-file write types and sizing for the writeback arbiter.
// The optional RF_WR_STATS_EN build also uses STATS_W for its conflict counter.
package rf_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned ADDR_W     = 3;
    localparam int unsigned NUM_REGS   = 1 << ADDR_W;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned CNT_W      = 2;
    localparam int unsigned STATS_W    = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] sel;
        logic [DATA_W-1:0] data;
    } rf_wr_t;

    typedef enum logic {
        RR_REQ0 = 1'b0,
        RR_REQ1 = 1'b1
    } rr_t;

    // One-hot decode of a register select, used to build the pending mask.
    function automatic logic [NUM_REGS-1:0] sel_onehot(input logic [ADDR_W-1:0] sel);
        return NUM_REGS'(1) << sel;
    endfunction

endpackage

// File: rtl/rf_wr_arbiter_if.sv
// Writeback request/response bundle between the two requesters, the arbiter and rf_bypass.
interface rf_wr_arbiter_if;
    import rf_pkg::*;

    logic                req0_valid;
    logic                req0_ready;
    logic [ADDR_W-1:0]   req0_sel;
    logic [DATA_W-1:0]   req0_data;
    logic                req1_valid;
    logic                req1_ready;
    logic [ADDR_W-1:0]   req1_sel;
    logic [DATA_W-1:0]   req1_data;
    logic                write;
    logic [ADDR_W-1:0]   writeregsel;
    logic [DATA_W-1:0]   writedata;
    logic                rf_err;
    logic                err;
    logic [NUM_REGS-1:0] pending;

    modport slave (
        input  req0_valid, req0_sel, req0_data,
        input  req1_valid, req1_sel, req1_data,
        input  rf_err,
        output req0_ready, req1_ready,
        output write, writeregsel, writedata,
        output err, pending
    );

    modport master (
        output req0_valid, req0_sel, req0_data,
        output req1_valid, req1_sel, req1_data,
        output rf_err,
        input  req0_ready, req1_ready,
        input  write, writeregsel, writedata,
        input  err, pending
    );

endinterface

// File: rtl/wr_fifo2.sv
// Two-entry FIFO of register writes; slot0 is always the head.
module wr_fifo2
    import rf_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  rf_wr_t           din,
    output rf_wr_t           slot0,
    output rf_wr_t           slot1,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic             push_ok;
    logic             pop_ok;
    logic [CNT_W-1:0] cnt_nxt;

    // A full FIFO refuses pushes even when the head is popped in the same cycle.
    always_comb begin
        push_ok = push & ~full;
        pop_ok  = pop & ~empty;
        cnt_nxt = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            count <= cnt_nxt;
            full  <= (cnt_nxt == CNT_W'(FIFO_DEPTH));
            empty <= (cnt_nxt == '0);
            if (pop_ok) begin
                slot0 <= slot1;
            end
            // Push lands in the first free slot after the pop has shifted.
            if (push_ok) begin
                if ((count == '0) || ((count == CNT_W'(1)) && pop_ok)) begin
                    slot0 <= din;
                end else begin
                    slot1 <= din;
                end
            end
        end
    end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter sharing the rf_bypass write port between ALU and load writeback.
// Define RF_WR_STATS_EN to add the saturating conflict_cnt output.
module rf_wr_arbiter
    import rf_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    rf_wr_arbiter_if.slave     bus
`ifdef RF_WR_STATS_EN
    ,
    output logic [STATS_W-1:0] conflict_cnt
`endif
);

    rf_wr_t              f0_s0, f0_s1, f1_s0, f1_s1;
    logic [CNT_W-1:0]    f0_cnt, f1_cnt;
    logic                f0_full, f0_empty, f1_full, f1_empty;
    logic                gnt0, gnt1, both_c;
    rr_t                 rr, rr_nxt;
    logic                write_q;
    logic [ADDR_W-1:0]   sel_q;
    logic [DATA_W-1:0]   data_q;
    logic                err_q;
    logic [NUM_REGS-1:0] pend;

    wr_fifo2 u_fifo0 (
        .clk   (clk),
        .rst_n (rst),
        .push  (bus.req0_valid),
        .pop   (gnt0),
        .din   ({bus.req0_sel, bus.req0_data}),
        .slot0 (f0_s0),
        .slot1 (f0_s1),
        .count (f0_cnt),
        .full  (f0_full),
        .empty (f0_empty)
    );

    wr_fifo2 u_fifo1 (
        .clk   (clk),
        .rst_n (rst),
        .push  (bus.req1_valid),
        .pop   (gnt1),
        .din   ({bus.req1_sel, bus.req1_data}),
        .slot0 (f1_s0),
        .slot1 (f1_s1),
        .count (f1_cnt),
        .full  (f1_full),
        .empty (f1_empty)
    );

    // Grant on FIFO heads; the pointer always ends up on the requester not served.
    always_comb begin
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        rr_nxt = rr;
        both_c = ~f0_empty & ~f1_empty;
        if (both_c) begin
            if (rr == RR_REQ0) begin
                gnt0 = 1'b1;
            end else begin
                gnt1 = 1'b1;
            end
            rr_nxt = (rr == RR_REQ0) ? RR_REQ1 : RR_REQ0;
        end else if (!f0_empty) begin
            gnt0   = 1'b1;
            rr_nxt = RR_REQ1;
        end else if (!f1_empty) begin
            gnt1   = 1'b1;
            rr_nxt = RR_REQ0;
        end
    end

    // Write stage: select/data hold their last value while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr      <= RR_REQ0;
            write_q <= 1'b0;
            sel_q   <= '0;
            data_q  <= '0;
        end else begin
            rr      <= rr_nxt;
            write_q <= gnt0 | gnt1;
            if (gnt0) begin
                sel_q  <= f0_s0.sel;
                data_q <= f0_s0.data;
            end else if (gnt1) begin
                sel_q  <= f1_s0.sel;
                data_q <= f1_s0.data;
            end
        end
    end

    // Sticky error; an unknown write strobe is treated as a possible write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (bus.rf_err && (write_q !== 1'b0)) begin
            err_q <= 1'b1;
        end
    end

    always_comb begin
        pend = '0;
        if (f0_cnt != '0)        pend |= sel_onehot(f0_s0.sel);
        if (f0_cnt > CNT_W'(1))  pend |= sel_onehot(f0_s1.sel);
        if (f1_cnt != '0)        pend |= sel_onehot(f1_s0.sel);
        if (f1_cnt > CNT_W'(1))  pend |= sel_onehot(f1_s1.sel);
        if (write_q)             pend |= sel_onehot(sel_q);
    end

`ifdef RF_WR_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_cnt <= '0;
        end else if (both_c && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + STATS_W'(1);
        end
    end
`endif

    assign bus.req0_ready  = ~f0_full;
    assign bus.req1_ready  = ~f1_full;
    assign bus.write       = write_q;
    assign bus.writeregsel = sel_q;
    assign bus.writedata   = data_q;
    assign bus.err         = err_q;
    assign bus.pending     = pend;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Scoreboard bench for rf_wr_arbiter: a cycle model of both FIFOs and the round-robin grant.
module tb_rf_wr_arbiter;
    import rf_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_wr_arbiter_if bus ();
`ifdef RF_WR_STATS_EN
    logic [STATS_W-1:0] conflict_cnt;
`endif

    rf_wr_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef RF_WR_STATS_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    int checks = 0;
    int failures = 0;

    rf_wr_t            m0[$];
    rf_wr_t            m1[$];
    bit                mrr;
    bit                exp_w;
    logic [ADDR_W-1:0] exp_sel;
    logic [DATA_W-1:0] exp_data;
    bit                exp_err;
    int                exp_cnt;
    bit                acc0, acc1;
    int                writes_seen;
    int                accepted;
    logic [ADDR_W-1:0] wseq[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NUM_REGS-1:0] model_pend();
        logic [NUM_REGS-1:0] p = '0;
        foreach (m0[i]) p[m0[i].sel] = 1'b1;
        foreach (m1[i]) p[m1[i].sel] = 1'b1;
        if (exp_w) p[exp_sel] = 1'b1;
        return p;
    endfunction

    task automatic model_reset();
        m0.delete();
        m1.delete();
        mrr = 1'b0;
        exp_w = 1'b0;
        exp_sel = '0;
        exp_data = '0;
        exp_err = 1'b0;
        exp_cnt = 0;
        acc0 = 1'b0;
        acc1 = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs held before it.
    task automatic model_edge();
        bit both;
        int g;
        rf_wr_t e;
        acc0 = bus.req0_valid && (m0.size() < 2);
        acc1 = bus.req1_valid && (m1.size() < 2);
        both = (m0.size() > 0) && (m1.size() > 0);
        if (both && exp_cnt < 65535) exp_cnt++;
        if (bus.rf_err && exp_w) exp_err = 1'b1;
        g = -1;
        if (both) begin
            g = mrr ? 1 : 0;
            mrr = !mrr;
        end else if (m0.size() > 0) begin
            g = 0;
            mrr = 1'b1;
        end else if (m1.size() > 0) begin
            g = 1;
            mrr = 1'b0;
        end
        exp_w = (g >= 0);
        if (g == 0) e = m0.pop_front();
        if (g == 1) e = m1.pop_front();
        if (g >= 0) begin
            exp_sel = e.sel;
            exp_data = e.data;
        end
        if (acc0) begin
            m0.push_back({bus.req0_sel, bus.req0_data});
            accepted++;
        end
        if (acc1) begin
            m1.push_back({bus.req1_sel, bus.req1_data});
            accepted++;
        end
    endtask

    task automatic compare_all();
        check_eq("write", 32'(bus.write), 32'(exp_w));
        check_eq("writeregsel", 32'(bus.writeregsel), 32'(exp_sel));
        check_eq("writedata", 32'(bus.writedata), 32'(exp_data));
        check_eq("pending", 32'(bus.pending), 32'(model_pend()));
        check_eq("req0_ready", 32'(bus.req0_ready), 32'(m0.size() < 2));
        check_eq("req1_ready", 32'(bus.req1_ready), 32'(m1.size() < 2));
        check_eq("err", 32'(bus.err), 32'(exp_err));
`ifdef RF_WR_STATS_EN
        check_eq("conflict_cnt", 32'(conflict_cnt), 32'(exp_cnt));
`endif
        if (bus.write === 1'b1) begin
            writes_seen++;
            wseq.push_back(bus.writeregsel);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    // Entered and left at a falling edge.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rf_err = 1'b0;
    endtask

    // Both requesters push every cycle; data advances only when accepted.
    task automatic run_both(input int cycles, input logic [ADDR_W-1:0] s0, input logic [ADDR_W-1:0] s1);
        int n0 = 0;
        int n1 = 0;
        for (int c = 0; c < cycles; c++) begin
            bus.req0_valid = 1'b1;
            bus.req0_sel = s0;
            bus.req0_data = 16'h0100 + DATA_W'(n0);
            bus.req1_valid = 1'b1;
            bus.req1_sel = s1;
            bus.req1_data = 16'h0200 + DATA_W'(n1);
            step();
            if (acc0) n0++;
            if (acc1) n1++;
        end
    endtask

    initial begin
        bit saw_r1_low;
        idle_inputs();
        bus.req0_sel = '0;
        bus.req0_data = '0;
        bus.req1_sel = '0;
        bus.req1_data = '0;
        rst = 1'b1;
        writes_seen = 0;
        accepted = 0;
        model_reset();
        @(negedge clk);
        do_reset();
        check_eq("rst_write", 32'(bus.write), 32'd0);
        check_eq("rst_pending", 32'(bus.pending), 32'd0);
        check_eq("rst_ready0", 32'(bus.req0_ready), 32'd1);

        // Single ALU write: latency and pending window.
        bus.req0_valid = 1'b1;
        bus.req0_sel = 3'd3;
        bus.req0_data = 16'h1234;
        step();
        bus.req0_valid = 1'b0;
        check_eq("t1_c1_write", 32'(bus.write), 32'd0);
        check_eq("t1_c1_pend3", 32'(bus.pending[3]), 32'd1);
        step();
        check_eq("t1_c2_write", 32'(bus.write), 32'd1);
        check_eq("t1_c2_sel", 32'(bus.writeregsel), 32'd3);
        check_eq("t1_c2_data", 32'(bus.writedata), 32'h1234);
        check_eq("t1_c2_pend3", 32'(bus.pending[3]), 32'd1);
        step();
        check_eq("t1_c3_write", 32'(bus.write), 32'd0);
        check_eq("t1_c3_pend", 32'(bus.pending), 32'd0);

        // Contention: alternating grants starting with req0, readys drop, nothing lost.
        do_reset();
        wseq.delete();
        writes_seen = 0;
        accepted = 0;
        saw_r1_low = 1'b0;
        for (int c = 0; c < 12; c++) begin
            run_both(1, 3'd1, 3'd2);
            if (bus.req1_ready === 1'b0) saw_r1_low = 1'b1;
        end
        check_eq("t2_r1_ready_drop", 32'(saw_r1_low), 32'd1);
        check_eq("t2_seq0", 32'(wseq[0]), 32'd1);
        check_eq("t2_seq1", 32'(wseq[1]), 32'd2);
        check_eq("t2_seq2", 32'(wseq[2]), 32'd1);
        check_eq("t2_seq3", 32'(wseq[3]), 32'd2);
        idle_inputs();
        for (int c = 0; c < 8; c++) step();
        check_eq("t3_no_loss", 32'(writes_seen), 32'(accepted));

        // Reset with both FIFOs loaded discards everything at once.
        run_both(3, 3'd5, 3'd6);
        idle_inputs();
        rst = 1'b0;
        #1;
        check_eq("t4_write", 32'(bus.write), 32'd0);
        check_eq("t4_pending", 32'(bus.pending), 32'd0);
        check_eq("t4_err", 32'(bus.err), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        writes_seen = 0;
        for (int c = 0; c < 5; c++) step();
        check_eq("t4_no_writes", 32'(writes_seen), 32'd0);

        // rf_err outside a write is ignored; during a write it sticks.
        bus.rf_err = 1'b1;
        step();
        bus.rf_err = 1'b0;
        check_eq("t5_no_err", 32'(bus.err), 32'd0);
        bus.req0_valid = 1'b1;
        bus.req0_sel = 3'd7;
        bus.req0_data = 16'hBEEF;
        step();
        bus.req0_valid = 1'b0;
        for (int c = 0; c < 6 && bus.write !== 1'b1; c++) step();
        check_eq("t5_wait_write", 32'(bus.write), 32'd1);
        bus.rf_err = 1'b1;
        step();
        bus.rf_err = 1'b0;
        check_eq("t5_err_set", 32'(bus.err), 32'd1);
        for (int c = 0; c < 3; c++) step();
        check_eq("t5_err_sticky", 32'(bus.err), 32'd1);
        do_reset();
        check_eq("t5_err_cleared", 32'(bus.err), 32'd0);

`ifdef RF_WR_STATS_EN
        // Conflict counter: five contended cycles, then run into saturation.
        run_both(6, 3'd1, 3'd2);
        check_eq("t6_cnt5", 32'(conflict_cnt), 32'd5);
        run_both(65535, 3'd1, 3'd2);
        check_eq("t6_cnt_sat", 32'(conflict_cnt), 32'hFFFF);
        idle_inputs();
        do_reset();
        check_eq("t6_cnt_rst", 32'(conflict_cnt), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
